// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with a rotating priority pointer and a grant-hold FSM.
// Define ARB_TIMEOUT_EN to cap a grant at MAX_HOLD cycles and pulse timeout on revocation.
module rr_arbiter8 #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_id,
   output logic       gnt_vld,
   output logic       timeout
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("rr_arbiter8: MAX_HOLD must be in 2..255");
   end

   // Lowest set bit wins; an empty vector encodes as 0.
   function automatic logic [2:0] pri_enc8(input logic [7:0] v);
      pri_enc8 = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) begin
            pri_enc8 = 3'(i);
         end
      end
   endfunction

   // Rotate right so that bit s of v lands at position 0.
   function automatic logic [7:0] rotr8(input logic [7:0] v, input logic [2:0] s);
      logic [2:0] idx;
      rotr8 = 8'h00;
      for (int i = 0; i < 8; i++) begin
         idx      = 3'(i) + s;
         rotr8[i] = v[idx];
      end
   endfunction

   state_t     r_state, w_state_nxt;
   logic [2:0] r_ptr, w_ptr_nxt;
   logic [7:0] r_gnt, w_gnt_nxt;
   logic [2:0] r_gnt_id, w_gnt_id_nxt;
   logic       r_vld, w_vld_nxt;
   logic [2:0] w_win;
   logic       w_own_req;
   logic       w_revoke;

   // Winner index is relative to the pointer, then shifted back to an absolute index.
   assign w_win     = pri_enc8(rotr8(req, r_ptr)) + r_ptr;
   assign w_own_req = req[r_gnt_id];

`ifdef ARB_TIMEOUT_EN
   logic [7:0] r_hold, w_hold_nxt;
   logic       r_timeout, w_timeout_nxt;

   assign w_revoke = (r_hold == 8'(MAX_HOLD - 1));
   assign timeout  = r_timeout;

   // Hold counter: zero while idle so the first BUSY cycle starts at 0.
   always_comb begin
      w_hold_nxt    = 8'd0;
      w_timeout_nxt = 1'b0;
      if (r_state == S_BUSY) begin
         w_hold_nxt    = r_hold + 8'd1;
         w_timeout_nxt = w_own_req && w_revoke;
      end else begin
         w_hold_nxt    = 8'd0;
         w_timeout_nxt = 1'b0;
      end
   end

   // Hold counter and timeout pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold    <= 8'd0;
         r_timeout <= 1'b0;
      end else begin
         r_hold    <= w_hold_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end
`else
   assign w_revoke = 1'b0;
   assign timeout  = 1'b0;
`endif

   // Next-state and next-grant logic; a release takes precedence over a revocation.
   always_comb begin
      w_state_nxt  = r_state;
      w_ptr_nxt    = r_ptr;
      w_gnt_nxt    = r_gnt;
      w_gnt_id_nxt = r_gnt_id;
      w_vld_nxt    = r_vld;
      case (r_state)
         S_IDLE: begin
            if (req != 8'h00) begin
               w_state_nxt  = S_BUSY;
               w_gnt_nxt    = 8'h01 << w_win;
               w_gnt_id_nxt = w_win;
               w_vld_nxt    = 1'b1;
            end else begin
               w_gnt_nxt    = 8'h00;
               w_gnt_id_nxt = 3'd0;
               w_vld_nxt    = 1'b0;
            end
         end
         S_BUSY: begin
            if (!w_own_req || w_revoke) begin
               w_state_nxt  = S_IDLE;
               w_ptr_nxt    = r_gnt_id + 3'd1;
               w_gnt_nxt    = 8'h00;
               w_gnt_id_nxt = 3'd0;
               w_vld_nxt    = 1'b0;
            end else begin
               w_state_nxt  = S_BUSY;
            end
         end
         default: begin
            w_state_nxt  = S_IDLE;
            w_ptr_nxt    = 3'd0;
            w_gnt_nxt    = 8'h00;
            w_gnt_id_nxt = 3'd0;
            w_vld_nxt    = 1'b0;
         end
      endcase
   end

   // State, pointer and registered grant outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_ptr    <= 3'd0;
         r_gnt    <= 8'h00;
         r_gnt_id <= 3'd0;
         r_vld    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_ptr    <= w_ptr_nxt;
         r_gnt    <= w_gnt_nxt;
         r_gnt_id <= w_gnt_id_nxt;
         r_vld    <= w_vld_nxt;
      end
   end

   assign gnt     = r_gnt;
   assign gnt_id  = r_gnt_id;
   assign gnt_vld = r_vld;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios with literal expectations, then random traffic
// compared every cycle against a behavioural owner/pointer model.
module tb_rr_arbiter8;

`ifdef ARB_TIMEOUT_EN
   localparam int MAX_HOLD = 4;
   localparam bit TO_EN    = 1'b1;
`else
   localparam int MAX_HOLD = 16;
   localparam bit TO_EN    = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_vld;
   logic       timeout;

   int total = 0;
   int bad   = 0;

   // model state: owner is -1 when nothing is granted, hold counts visible grant cycles
   int m_owner = -1;
   int m_ptr   = 0;
   int m_hold  = 0;
   bit m_to    = 1'b0;
   bit m_valid = 1'b0;

   rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .gnt_vld (gnt_vld),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model advanced on every rising edge from the same sampled inputs.
   always @(posedge clk) begin
      if (rst) begin
         m_owner = -1; m_ptr = 0; m_hold = 0; m_to = 1'b0; m_valid = 1'b1;
      end else if (m_owner < 0) begin
         m_to = 1'b0;
         for (int k = 0; k < 8; k++) begin
            if (m_owner < 0 && req[(m_ptr + k) % 8]) begin
               m_owner = (m_ptr + k) % 8;
               m_hold  = 1;
            end
         end
      end else if (!req[m_owner]) begin
         m_ptr = (m_owner + 1) % 8; m_owner = -1; m_to = 1'b0;
      end else if (TO_EN && m_hold == MAX_HOLD) begin
         m_ptr = (m_owner + 1) % 8; m_owner = -1; m_to = 1'b1;
      end else begin
         m_hold++; m_to = 1'b0;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("m_gnt", gnt, (m_owner < 0) ? 8'h00 : (8'h01 << m_owner));
         chk("m_gnt_id", {5'd0, gnt_id}, (m_owner < 0) ? 8'h00 : 8'(m_owner));
         chk("m_gnt_vld", {7'd0, gnt_vld}, {7'd0, (m_owner >= 0)});
         chk("m_timeout", {7'd0, timeout}, {7'd0, m_to});
         chk("m_onehot0", {7'd0, $onehot0(gnt)}, 8'h01);
      end
   end

   // apply inputs, let one rising edge consume them, return just after that edge
   task automatic tick(input logic [7:0] r, input logic rs);
      req = r;
      rst = rs;
      @(posedge clk);
      #1;
   endtask

   logic [7:0] rv;

   initial begin
      req = 8'h00;
      rst = 1'b1;
      // reset then idle
      tick(8'h00, 1'b1);
      tick(8'h00, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick(8'h00, 1'b0);
         chk("idle_gnt", gnt, 8'h00);
         chk("idle_vld", {7'd0, gnt_vld}, 8'h00);
      end
      // single requester, then wrap of the search from ptr=6 to bit 0
      tick(8'h20, 1'b0);
      chk("single_gnt", gnt, 8'h20);
      chk("single_id", {5'd0, gnt_id}, 8'd5);
      tick(8'h00, 1'b0);
      chk("single_rel", gnt, 8'h00);
      tick(8'h01, 1'b0);
      chk("wrap_id", {5'd0, gnt_id}, 8'd0);
      chk("wrap_gnt", gnt, 8'h01);
      tick(8'h00, 1'b0);
      // rotation with all requesting
      tick(8'h00, 1'b1);
      for (int k = 0; k < 9; k++) begin
         tick(8'hFF, 1'b0);
         chk("rot_id", {5'd0, gnt_id}, 8'(k % 8));
         tick(8'hFF, 1'b0);
         chk("rot_hold", gnt, 8'h01 << (k % 8));
         rv = 8'hFF & ~(8'h01 << (k % 8));
         tick(rv, 1'b0);
         chk("rot_dead", {7'd0, gnt_vld}, 8'h00);
      end
      // stability while other bits change
      tick(8'h00, 1'b1);
      tick(8'h08, 1'b0);
      chk("stab_g0", gnt, 8'h08);
      tick(8'hF8, 1'b0);
      chk("stab_g1", gnt, 8'h08);
      tick(8'h0C, 1'b0);
      chk("stab_g2", gnt, 8'h08);
      tick(8'h04, 1'b0);
      chk("stab_rel", gnt, 8'h00);
      tick(8'h04, 1'b0);
      chk("stab_next", {5'd0, gnt_id}, 8'd2);
      // reset mid-grant
      tick(8'h00, 1'b1);
      tick(8'h40, 1'b0);
      chk("mid_g6", {5'd0, gnt_id}, 8'd6);
      tick(8'h40, 1'b1);
      chk("mid_rst_gnt", gnt, 8'h00);
      chk("mid_rst_vld", {7'd0, gnt_vld}, 8'h00);
      tick(8'hC1, 1'b0);
      chk("mid_after", {5'd0, gnt_id}, 8'd0);
`ifdef ARB_TIMEOUT_EN
      tick(8'h00, 1'b1);
      tick(8'h81, 1'b0);
      chk("to_g0", gnt, 8'h01);
      for (int i = 0; i < 3; i++) begin
         tick(8'h81, 1'b0);
         chk("to_hold", gnt, 8'h01);
      end
      tick(8'h81, 1'b0);
      chk("to_gnt", gnt, 8'h00);
      chk("to_pulse", {7'd0, timeout}, 8'h01);
      tick(8'h81, 1'b0);
      chk("to_next", {5'd0, gnt_id}, 8'd7);
      chk("to_clear", {7'd0, timeout}, 8'h00);
`endif
      // random traffic; the owner tends to keep its bit high so grants last several cycles
      tick(8'h00, 1'b1);
      for (int i = 0; i < 3000; i++) begin
         rv = 8'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            rv = 8'h00;
         end
         if (m_owner >= 0 && $urandom_range(0, 4) != 0) begin
            rv[m_owner] = 1'b1;
         end
         tick(rv, ($urandom_range(0, 199) == 0));
      end
      tick(8'h00, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
